// File: rtl/legv8_mem_pkg.sv
// Shared definitions for the LEGv8 load/store controller: access sizes, fault codes,
// FSM states and default RAM geometry.
package legv8_mem_pkg;

    localparam int MEM_WORDS_DEFAULT = 6000;
    localparam int ADDR_W_DEFAULT    = 13;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_RANGE    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_t;

    // One bit per byte lane covered by an access of the given size, at offset 0.
    function automatic logic [7:0] byte_mask(input logic [1:0] size);
        case (size)
            SZ_B:    byte_mask = 8'h01;
            SZ_H:    byte_mask = 8'h03;
            SZ_W:    byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] low_mask(input logic [1:0] size);
        case (size)
            SZ_B:    low_mask = 3'd0;
            SZ_H:    low_mask = 3'd1;
            SZ_W:    low_mask = 3'd3;
            default: low_mask = 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/legv8_mem_ctrl_lane_align.sv
// legv8_lane_align: byte-lane extraction with zero/sign extension for loads,
// and lane merge of right-justified store data into an existing word.
module legv8_lane_align
    import legv8_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [2:0]  offset,
    input  logic        sign_ext,
    input  logic [63:0] rd_word,
    input  logic [63:0] old_word,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] merge_word
);
    logic [5:0]  shamt;
    logic [7:0]  field_bytes;
    logic [7:0]  store_bytes;
    logic [63:0] field_mask;
    logic [63:0] rd_shifted;
    logic [63:0] wdata_shifted;
    logic        sign_bit;

    assign shamt         = {offset, 3'b000};
    assign field_bytes   = byte_mask(size);
    assign store_bytes   = field_bytes << offset;
    assign rd_shifted    = rd_word >> shamt;
    assign wdata_shifted = wdata << shamt;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign field_mask[8*gi +: 8] = {8{field_bytes[gi]}};
            assign merge_word[8*gi +: 8] = store_bytes[gi] ? wdata_shifted[8*gi +: 8]
                                                           : old_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        case (size)
            SZ_B:    sign_bit = rd_shifted[7];
            SZ_H:    sign_bit = rd_shifted[15];
            SZ_W:    sign_bit = rd_shifted[31];
            default: sign_bit = 1'b0;
        endcase
    end

    // Doubles never extend: sign_bit is forced low and field_mask is all ones.
    assign load_data = (rd_shifted & field_mask) |
                       ((sign_ext && sign_bit) ? ~field_mask : 64'd0);

endmodule

// File: rtl/legv8_mem_ctrl.sv
// legv8_mem_ctrl: MEM-stage load/store controller in front of a 64-bit word RAM.
// Define LEGV8_MEMCTRL_FAULT_EN to enable misalignment and range fault reporting.
module legv8_mem_ctrl
    import legv8_mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic [1:0]        resp_fault,
    output logic [ADDR_W-1:0] ram_address,
    output logic [63:0]       ram_in,
    output logic              ram_write,
    input  logic [63:0]       ram_out
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       merge_q, merge_d;
    logic              resp_valid_q, resp_valid_d;
    logic [63:0]       resp_rdata_q, resp_rdata_d;
    logic [1:0]        resp_fault_q, resp_fault_d;

    logic              accept;
    logic [ADDR_W-1:0] idx_in;
    logic [2:0]        off_in;
    logic [1:0]        fault_in;
    logic [63:0]       load_data;
    logic [63:0]       merge_data;

    assign idx_in    = req_addr[ADDR_W+2:3];
    assign req_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign accept    = req_valid && req_ready;

`ifdef LEGV8_MEMCTRL_FAULT_EN
    logic idx_oor;
    assign idx_oor = ({{(32-ADDR_W){1'b0}}, idx_in} >= 32'(MEM_WORDS));
    assign off_in  = req_addr[2:0];

    always_comb begin
        fault_in = FLT_NONE;
        if ((req_addr[2:0] & low_mask(req_size)) != 3'd0) begin
            fault_in = FLT_MISALIGN;
        end else if ((|req_addr[63:ADDR_W+3]) || idx_oor) begin
            fault_in = FLT_RANGE;
        end
    end
`else
    // Without fault checking the address wraps and the offset is aligned down.
    logic unused_range_inputs;
    assign unused_range_inputs = (^req_addr[63:ADDR_W+3]) ^ (MEM_WORDS == 0);
    assign off_in   = req_addr[2:0] & ~low_mask(req_size);
    assign fault_in = FLT_NONE;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (!accept)                  state_d = ST_IDLE;
                else if (fault_in != FLT_NONE) state_d = ST_RESP;
                else if (!req_write)          state_d = ST_READ;
                else if (req_size == SZ_D)    state_d = ST_WRITE;
                else                          state_d = ST_RMW_RD;
            end
            ST_READ, ST_WRITE, ST_RMW_WR: state_d = ST_RESP;
            ST_RMW_RD:                    state_d = ST_RMW_WR;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // Gating with reset_n aborts a store caught by reset in its write cycle.
        ram_write    = reset_n && ((state_q == ST_WRITE) || (state_q == ST_RMW_WR));
        ram_in       = (state_q == ST_RMW_WR) ? merge_data : wdata_q;
        addr_d       = addr_q;
        off_d        = off_q;
        size_d       = size_q;
        signed_d     = signed_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_valid_d = (state_d == ST_RESP);
        resp_rdata_d = 64'd0;
        resp_fault_d = FLT_NONE;
        if (accept) begin
            if (fault_in != FLT_NONE) begin
                resp_fault_d = fault_in;
            end else begin
                addr_d   = idx_in;
                off_d    = off_in;
                size_d   = req_size;
                signed_d = req_signed;
                wdata_d  = req_wdata;
            end
        end
        if (state_q == ST_READ)   resp_rdata_d = load_data;
        if (state_q == ST_RMW_RD) merge_d      = ram_out;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr_q       <= '0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= FLT_NONE;
        end else begin
            addr_q       <= addr_d;
            off_q        <= off_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign ram_address = addr_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_fault  = resp_fault_q;

    legv8_lane_align u_align (
        .size       (size_q),
        .offset     (off_q),
        .sign_ext   (signed_q),
        .rd_word    (ram_out),
        .old_word   (merge_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_word (merge_data)
    );

endmodule

// File: tb/tb_legv8_mem_ctrl.sv
// Self-checking bench for legv8_mem_ctrl: directed steps, a reset-abort case and a
// back-to-back random stream checked against a byte-level memory model.
module tb_legv8_mem_ctrl;

    localparam int MEM_WORDS = 6000;
    localparam int ADDR_W    = 13;
    localparam int RAM_DEPTH = 8192;
    localparam int N_STREAM  = 40;

    logic              clock;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [63:0]       req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic [1:0]        resp_fault;
    logic [ADDR_W-1:0] ram_address;
    logic [63:0]       ram_in;
    logic              ram_write;
    logic [63:0]       ram_out;

    bit [63:0] mem     [0:RAM_DEPTH-1];
    bit [63:0] ref_mem [0:RAM_DEPTH-1];

    int total = 0;
    int bad   = 0;
    int wr_count = 0;
    int last_wr_idx = -1;

    legv8_mem_ctrl #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_write   (ram_write),
        .ram_out     (ram_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM: write on posedge, read data captured on negedge.
    always @(posedge clock) if (ram_write === 1'b1) mem[ram_address] = ram_in;
    always @(negedge clock) ram_out = mem[ram_address];

    always @(negedge clock) begin
        if (ram_write === 1'b1) begin
            wr_count++;
            last_wr_idx = int'(ram_address);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: applies stores to ref_mem, predicts load value, fault, latency.
    function automatic void model_txn(input bit w, input int size, input bit sg,
                                      input logic [63:0] addr, input logic [63:0] wd,
                                      output logic [63:0] rdata, output logic [1:0] fault,
                                      output int lat);
        int nb;
        int idx;
        int off;
        nb    = 1 << size;
        rdata = 64'd0;
        fault = 2'd0;
        lat   = 2;
`ifdef LEGV8_MEMCTRL_FAULT_EN
        if (addr % nb != 0)                   fault = 2'd1;
        else if (addr >= 64'(MEM_WORDS * 8)) fault = 2'd2;
        if (fault != 2'd0) begin
            lat = 1;
            return;
        end
        off = int'(addr % 8);
`else
        off = (int'(addr % 8) / nb) * nb;
`endif
        idx = int'((addr / 8) % RAM_DEPTH);
        if (w) begin
            for (int b = 0; b < nb; b++) ref_mem[idx][8*(off+b) +: 8] = wd[8*b +: 8];
            lat = (nb == 8) ? 2 : 3;
        end else begin
            for (int b = 0; b < nb; b++) rdata[8*b +: 8] = ref_mem[idx][8*(off+b) +: 8];
            if (sg && nb < 8 && rdata[8*nb-1])
                for (int b = nb; b < 8; b++) rdata[8*b +: 8] = 8'hFF;
        end
    endfunction

    // One isolated transaction from IDLE; called just after a posedge.
    task automatic txn(input string tag, input bit w, input int size, input bit sg,
                       input logic [63:0] addr, input logic [63:0] wd,
                       output logic [63:0] obs_rdata, output logic [1:0] obs_fault);
        logic [63:0] exp_rdata;
        logic [1:0]  exp_fault;
        int          exp_lat;
        int          wr_before;
        int          lat;
        bit          got;
        model_txn(w, size, sg, addr, wd, exp_rdata, exp_fault, exp_lat);
        wr_before  = wr_count;
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = 2'(size);
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (req_ready === 1'b1) got = 1'b1;
            else @(posedge clock);
        end
        chk({tag, "_accepted"}, 64'(got), 64'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clock);
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                lat = i;
            end else begin
                @(posedge clock);
            end
        end
        obs_rdata = resp_rdata;
        obs_fault = resp_fault;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "_fault"}, 64'(resp_fault), 64'(exp_fault));
        chk({tag, "_ram_writes"}, 64'(wr_count - wr_before),
            64'((w && exp_fault == 2'd0) ? 1 : 0));
        $display("txn %s: w=%0d size=%0d signed=%0d addr=%h wdata=%h rdata=%h fault=%0d lat=%0d",
                 tag, w, size, sg, addr, wd, resp_rdata, resp_fault, lat);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk({tag, "_single_pulse"}, 64'(resp_valid), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic new_req();
        int sz;
        sz         = int'($urandom_range(0, 3));
        req_write  = 1'($urandom_range(0, 1));
        req_size   = 2'(sz);
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = 64'($urandom_range(0, 31)) * 64'd8 +
                     64'($urandom_range(0, (8 >> sz) - 1) << sz);
        req_wdata  = {$urandom, $urandom};
    endtask

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  fault;
        int          lat;
        int          acc_cyc;
    } exp_t;

    initial begin
        logic [63:0] r;
        logic [1:0]  f;
        exp_t        e;
        exp_t        pend[$];
        int          cyc;
        int          n_acc;
        int          n_rsp;
        int          wr_before;
        int          bad_words;
        bit          acc;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_resp_rdata", resp_rdata, 64'd0);
        chk("reset_resp_fault", 64'(resp_fault), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_ram_write", 64'(ram_write), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        txn("stur_40", 1'b1, 3, 1'b0, 64'h40, 64'h1122334455667788, r, f);
        chk("stur_40_index", 64'(last_wr_idx), 64'd8);
        chk("stur_40_word", mem[8], 64'h1122334455667788);
        txn("ldur_40", 1'b0, 3, 1'b0, 64'h40, 64'd0, r, f);
        chk("ldur_40_value", r, 64'h1122334455667788);

        txn("stur_ones", 1'b1, 3, 1'b0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, r, f);
        txn("sturb_43", 1'b1, 0, 1'b0, 64'h43, 64'h0000_0000_0000_00AB, r, f);
        chk("sturb_43_word", mem[8], 64'hFFFF_FFFF_ABFF_FFFF);
        txn("ldurb_43_u", 1'b0, 0, 1'b0, 64'h43, 64'd0, r, f);
        chk("ldurb_43_u_value", r, 64'h0000_0000_0000_00AB);
        txn("ldurb_43_s", 1'b0, 0, 1'b1, 64'h43, 64'd0, r, f);
        chk("ldurb_43_s_value", r, 64'hFFFF_FFFF_FFFF_FFAB);

        txn("stur_msb", 1'b1, 3, 1'b0, 64'h40, 64'h8000_0000_0000_0000, r, f);
        txn("ldursw_44", 1'b0, 2, 1'b1, 64'h44, 64'd0, r, f);
        chk("ldursw_44_value", r, 64'hFFFF_FFFF_8000_0000);
        txn("ldurw_44", 1'b0, 2, 1'b0, 64'h44, 64'd0, r, f);
        chk("ldurw_44_value", r, 64'h0000_0000_8000_0000);
        txn("ldur_msb_signed", 1'b0, 3, 1'b1, 64'h40, 64'd0, r, f);
        chk("ldur_msb_no_ext", r, 64'h8000_0000_0000_0000);

`ifdef LEGV8_MEMCTRL_FAULT_EN
        txn("ldurh_41", 1'b0, 1, 1'b0, 64'h41, 64'd0, r, f);
        chk("ldurh_41_code", 64'(f), 64'd1);
        txn("sturh_41", 1'b1, 1, 1'b0, 64'h41, 64'h1234, r, f);
        chk("sturh_41_code", 64'(f), 64'd1);
        txn("ldur_oor", 1'b0, 3, 1'b0, 64'(MEM_WORDS * 8), 64'd0, r, f);
        chk("ldur_oor_code", 64'(f), 64'd2);
        txn("ld_4g", 1'b0, 3, 1'b0, 64'h1_0000_0000, 64'd0, r, f);
        chk("ld_4g_code", 64'(f), 64'd2);
        txn("ldurh_oor_misal", 1'b0, 1, 1'b0, 64'h1_0000_0001, 64'd0, r, f);
        chk("misal_priority_code", 64'(f), 64'd1);
        txn("ldur_last_word", 1'b0, 3, 1'b0, 64'(MEM_WORDS * 8 - 8), 64'd0, r, f);
        chk("ldur_last_word_code", 64'(f), 64'd0);
`else
        txn("sturh_43_aligned", 1'b1, 1, 1'b0, 64'h43, 64'h1234, r, f);
        chk("sturh_43_word", mem[8], 64'h8000_0000_1234_0000);
        txn("ldur_wrap", 1'b0, 3, 1'b0, 64'h1_0000_0040, 64'd0, r, f);
        chk("ldur_wrap_value", r, 64'h8000_0000_1234_0000);
        chk("ldur_wrap_code", 64'(f), 64'd0);
`endif

        // Reset lands on the RMW_WR cycle of STURH 0xBEEF at 0x10.
        txn("stur_10", 1'b1, 3, 1'b0, 64'h10, 64'h0123_4567_89AB_CDEF, r, f);
        wr_before  = wr_count;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'd1;
        req_signed = 1'b0;
        req_addr   = 64'h10;
        req_wdata  = 64'hBEEF;
        @(negedge clock);
        chk("rst_abort_accept", 64'(req_ready), 64'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(negedge clock);
        chk("rst_abort_ram_write", 64'(ram_write), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_abort_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_abort_idle_ready", 64'(req_ready), 64'd1);
        chk("rst_abort_word", mem[2], 64'h0123_4567_89AB_CDEF);
        chk("rst_abort_writes", 64'(wr_count - wr_before), 64'd0);
        $display("txn rst_abort: sturh addr=0000000000000010 word2=%h", mem[2]);
        @(posedge clock);
        #1;

        // Back-to-back stream with req_valid held high.
        cyc   = 0;
        n_acc = 0;
        n_rsp = 0;
        new_req();
        req_valid = 1'b1;
        while (n_rsp < N_STREAM && cyc < 2000) begin
            @(negedge clock);
            if (resp_valid === 1'b1) begin
                if (pend.size() == 0) begin
                    chk("stream_unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = pend.pop_front();
                    chk("stream_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                    chk("stream_rdata", resp_rdata, e.rdata);
                    chk("stream_fault", 64'(resp_fault), 64'(e.fault));
                    $display("txn stream[%0d]: rdata=%h fault=%0d lat=%0d",
                             n_rsp, resp_rdata, resp_fault, cyc - e.acc_cyc);
                end
                n_rsp++;
            end
            acc = 1'b0;
            if (req_valid) begin
                if (n_acc > 0) chk("stream_ready_only_in_resp", 64'(req_ready), 64'(resp_valid));
                if (req_ready === 1'b1) begin
                    model_txn(req_write, int'(req_size), req_signed, req_addr, req_wdata,
                              e.rdata, e.fault, e.lat);
                    e.acc_cyc = cyc;
                    pend.push_back(e);
                    n_acc++;
                    acc = 1'b1;
                end
            end
            @(posedge clock);
            #1;
            cyc++;
            if (acc) begin
                if (n_acc < N_STREAM) new_req();
                else req_valid = 1'b0;
            end
        end
        chk("stream_resp_count", 64'(n_rsp), 64'(N_STREAM));
        chk("stream_pending_left", 64'(pend.size()), 64'd0);

        bad_words = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        chk("final_memory_words_differing", 64'(bad_words), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/legv8_mem_ctrl.md
Name: legv8_mem_ctrl

Overview:
- Load/store controller between the MEM pipeline stage and the 64-bit word data RAM.
- Converts LEGv8 byte addresses and sizes (LDUR/STUR, -W, -H, -B, LDURSW) into word accesses.
- Partial stores use read-modify-write. Loads return extracted, zero- or sign-extended results.
- Handles the RAM timing: write on posedge, read captured on negedge, and stalls the pipeline through `req_ready`.

Parameters:
- MEM_WORDS, 6000, number of 64-bit RAM words; a word index >= MEM_WORDS is out of range.
- ADDR_W, 13, width of the RAM word address.

Ports:
- clock  in  1  single system clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  controller accepts the request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_signed  in  1  sign-extend the load result (LDURSW and the like).
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  load result; 0 for stores and faults.
- resp_fault  out  2  0 = none, 1 = misaligned, 2 = out of range.
- ram_address  out  ADDR_W  to the RAM address.
- ram_in  out  64  to the RAM write data.
- ram_write  out  1  to the RAM write enable.
- ram_out  in  64  from the RAM read data.

Behaviour:
- Reset (reset_n = 0 at posedge):
  - state = IDLE.
  - resp_valid = 0, resp_rdata = 0, resp_fault = 0.
  - All internal registers cleared.
- ram_write is gated by reset_n, so no RAM write occurs at an edge where reset is asserted. This includes reset mid-WRITE or mid-RMW_WR; the store is aborted.
- Address decode:
  - word index = req_addr[ADDR_W+2:3]; byte offset = req_addr[2:0].
  - Lanes are little-endian.
  - Alignment rule: offset must be a multiple of 2^size.
- Fault check at acceptance:
  - Misaligned has priority over range.
  - Range fault: req_addr[63:ADDR_W+3] != 0, or word index >= MEM_WORDS.
- req_ready = 1 in IDLE and RESP; 0 otherwise. Accept = req_valid & req_ready.
- States:
  - IDLE.
  - READ.
  - WRITE.
  - RMW_RD.
  - RMW_WR.
  - RESP.
- Transitions on accept (from IDLE or RESP):
  - fault -> RESP with resp_fault set; no RAM access.
  - load -> READ.
  - store, size 3 -> WRITE.
  - store, size < 3 -> RMW_RD.
  - From RESP with no accept -> IDLE.
- READ: ram_address = latched index, ram_write = 0. At the next posedge, ram_out is captured, extracted and extended into resp_rdata. Next state RESP.
- WRITE: ram_in = latched wdata, ram_write = 1. Next state RESP.
- RMW_RD: ram_write = 0; ram_out is captured into merge_reg at the posedge. Next state RMW_WR.
- RMW_WR: ram_in = merge_reg with the sized lanes at the offset replaced from wdata; ram_write = 1. Next state RESP.
- RESP: resp_valid = 1 for exactly one cycle; outputs are registered.
- Latency from the accept cycle to the resp_valid cycle:
  - load: 2.
  - double store: 2.
  - partial store: 3.
  - fault: 1.
- Back-to-back: a request accepted in RESP starts immediately, giving no bubble.
- Outside READ/WRITE/RMW states, ram_address holds its last value and ram_write = 0.
- Extension: a load with size 3 ignores req_signed. Sizes below 3 zero-extend unless req_signed, in which case they sign-extend.

Optional Feature:
- Macro: LEGV8_MEMCTRL_FAULT_EN.
- Defined: alignment and range checks as above.
- Undefined:
  - resp_fault is tied to 0.
  - Offset bits below the access size are ignored (the address is aligned down).
  - The word index is taken modulo 2^ADDR_W with no range check.
  - Fault-path latency does not exist.

Decomposition:
- Shared package legv8_mem_pkg:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
  - fault codes;
  - state encoding;
  - default MEM_WORDS.
- One combinational sub-module, legv8_lane_align: extract plus sign/zero-extend for loads, and lane merge for stores. The FSM stays in legv8_mem_ctrl.

Test Plan:
- STUR 0x1122334455667788 at 0x40, then LDUR 0x40 -> ram_write pulses once at index 8; load resp_rdata = 0x1122334455667788 with resp_valid two cycles after accept.
- Preload word 8 = 0xFFFFFFFFFFFFFFFF; STURB 0xAB at 0x43 -> three-cycle latency; word becomes 0xFFFFFFFFABFFFFFF. LDURB 0x43 with signed = 0 -> 0xAB; with signed = 1 -> 0xFFFFFFFFFFFFFFAB.
- LDURSW at 0x44 with word 8 = 0x80000000_00000000 -> 0xFFFFFFFF80000000. LDUR (size 2, unsigned) at the same address -> 0x0000000080000000.
- With FAULT_EN defined:
  - LDURH at 0x41 -> resp_fault = 1, one cycle, no ram_write.
  - LDUR at 6000*8 -> resp_fault = 2.
  - A request at 0x1_0000_0000 -> resp_fault = 2.
- Deassert reset_n during the RMW_WR cycle of STURH 0xBEEF at 0x10 -> no RAM write; memory unchanged; next cycle state IDLE, resp_valid = 0.
- req_valid held high with alternating loads/stores -> req_ready low in the busy states. Each request is accepted in the RESP cycle of the previous one, with no dropped or duplicated responses.
